// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU decode stage:
//   - ALU operation codes and branch-compare codes
//   - RV32I / OP-FP opcode and funct7 constants
//   - immediate-format enum and the immediate generator
//   - ctrl_t, the packed E-stage control word
// ---------------------------------------------------------------------------
package alu_pkg;

    // ALU operation codes
    localparam logic [6:0] ALU_ADD    = 7'b0000000;
    localparam logic [6:0] ALU_SUB    = 7'b0000001;
    localparam logic [6:0] ALU_SCOMP  = 7'b0100100;
    localparam logic [6:0] ALU_SLL    = 7'b0101000;
    localparam logic [6:0] ALU_SRL    = 7'b0101100;
    localparam logic [6:0] ALU_SRA    = 7'b0110000;
    localparam logic [6:0] ALU_AND    = 7'b0110100;
    localparam logic [6:0] ALU_OR     = 7'b0111000;
    localparam logic [6:0] ALU_XOR    = 7'b0111100;
    localparam logic [6:0] ALU_LUI    = 7'b0100000;
    localparam logic [6:0] ALU_FMV    = 7'b0100001;
    localparam logic [6:0] ALU_FSGNJ  = 7'b0100010;
    localparam logic [6:0] ALU_FSGNJN = 7'b0100011;

    // Branch-compare codes
    localparam logic [1:0] BC_NONE = 2'b00;
    localparam logic [1:0] BC_EQ   = 2'b01;
    localparam logic [1:0] BC_LT   = 2'b10;
    localparam logic [1:0] BC_LTU  = 2'b11;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;

    // funct7 values
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_FSGNJ  = 7'b0010000;
    localparam logic [6:0] F7_FMV_XW = 7'b1110000;
    localparam logic [6:0] F7_FMV_WX = 7'b1111000;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SH
    } imm_fmt_e;

    // E-stage control word (everything except the data fields)
    typedef struct packed {
        logic [6:0] alu_control;
        logic [1:0] branch_control;
        logic       branch_inv;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       src_a_pc;
        logic       src_b_imm;
        logic       op_swap;
        logic       reg_write;
        logic       fp_dest;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } ctrl_t;

    // Sign extension always comes from instr[31]; shift amounts are
    // zero-extended from instr[24:20].
    function automatic logic [31:0] gen_imm(imm_fmt_e fmt, logic [31:0] instr);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SH:  imm = {27'b0, instr[24:20]};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// ---------------------------------------------------------------------------
// alu_decode_stage_if
// Bundles the IF/ID-side inputs, the pipeline controls and the ID/EX
// outputs of the decode stage.
//   master : upstream / pipeline control (drives D-side and StallE/FlushE)
//   slave  : the decode stage itself (drives all E-side outputs)
// ---------------------------------------------------------------------------
interface alu_decode_stage_if #(
    parameter int CNT_W = 8
);
    logic             InstrValidD;
    logic [31:0]      InstrD;
    logic [31:0]      PCD;
    logic             StallE;
    logic             FlushE;

    logic             ValidE;
    logic [6:0]       ALUControlE;
    logic [1:0]       BranchControlE;
    logic             BranchInvE;
    logic             BranchE;
    logic             JumpE;
    logic             JalrE;
    logic             ALUSrcAPCE;
    logic             ALUSrcBImmE;
    logic             OpSwapE;
    logic [31:0]      ImmE;
    logic [31:0]      PCE;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic             RegWriteE;
    logic             FpDestE;
    logic             MemReadE;
    logic             MemWriteE;
    logic             IllegalE;
    logic [CNT_W-1:0] IllegalCount;

    modport master (
        output InstrValidD, InstrD, PCD, StallE, FlushE,
        input  ValidE, ALUControlE, BranchControlE, BranchInvE, BranchE, JumpE,
               JalrE, ALUSrcAPCE, ALUSrcBImmE, OpSwapE, ImmE, PCE, Rs1E, Rs2E,
               RdE, RegWriteE, FpDestE, MemReadE, MemWriteE, IllegalE, IllegalCount
    );

    modport slave (
        input  InstrValidD, InstrD, PCD, StallE, FlushE,
        output ValidE, ALUControlE, BranchControlE, BranchInvE, BranchE, JumpE,
               JalrE, ALUSrcAPCE, ALUSrcBImmE, OpSwapE, ImmE, PCE, Rs1E, Rs2E,
               RdE, RegWriteE, FpDestE, MemReadE, MemWriteE, IllegalE, IllegalCount
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// ---------------------------------------------------------------------------
// alu_ctrl_dec
// Purely combinational decoder: RV32I plus fsgnj.s/fsgnjn.s/fmv.x.w/fmv.w.x
// into the E-stage control word and the sign-extended immediate.
//   instr_i : instruction word
//   ctrl_o  : control word (illegal encodings give only ctrl_o.illegal=1)
//   imm_o   : immediate (0 for R-type and illegal encodings)
// ---------------------------------------------------------------------------
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic [31:0] imm_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs2;
    logic       f7_ok;

    ctrl_t      ctrl_c;
    imm_fmt_e   fmt_c;
    logic       illegal_c;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];
    assign f7_ok  = (funct7 == F7_BASE) || (funct7 == F7_ALT);

    always_comb begin
        ctrl_c    = '0;
        fmt_c     = IMM_NONE;
        illegal_c = 1'b0;

        case (opcode)
            OPC_OP: begin
                ctrl_c.reg_write = 1'b1;
                // Only funct7=0100000 with add/sub or srl/sra is a legal alternate.
                if (!((funct7 == F7_BASE) ||
                      (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
                    illegal_c = 1'b1;
                end
                case (funct3)
                    3'b000: ctrl_c.alu_control = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001: ctrl_c.alu_control = ALU_SLL;
                    3'b010: begin ctrl_c.alu_control = ALU_SCOMP; ctrl_c.branch_control = BC_LT;  end
                    3'b011: begin ctrl_c.alu_control = ALU_SCOMP; ctrl_c.branch_control = BC_LTU; end
                    3'b100: ctrl_c.alu_control = ALU_XOR;
                    3'b101: ctrl_c.alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: ctrl_c.alu_control = ALU_OR;
                    default: ctrl_c.alu_control = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.src_b_imm = 1'b1;
                fmt_c            = IMM_I;
                case (funct3)
                    3'b000: ctrl_c.alu_control = ALU_ADD;
                    3'b001: begin
                        ctrl_c.alu_control = ALU_SLL;
                        fmt_c              = IMM_SH;
                        illegal_c          = !f7_ok;
                    end
                    3'b010: begin ctrl_c.alu_control = ALU_SCOMP; ctrl_c.branch_control = BC_LT;  end
                    3'b011: begin ctrl_c.alu_control = ALU_SCOMP; ctrl_c.branch_control = BC_LTU; end
                    3'b100: ctrl_c.alu_control = ALU_XOR;
                    3'b101: begin
                        ctrl_c.alu_control = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        fmt_c              = IMM_SH;
                        illegal_c          = !f7_ok;
                    end
                    3'b110: ctrl_c.alu_control = ALU_OR;
                    default: ctrl_c.alu_control = ALU_AND;
                endcase
            end
            OPC_BRANCH: begin
                // ALU compares rs1/rs2; funct3[0] selects the inverted sense.
                ctrl_c.branch     = 1'b1;
                ctrl_c.branch_inv = funct3[0];
                fmt_c             = IMM_B;
                case (funct3[2:1])
                    2'b00:   ctrl_c.branch_control = BC_EQ;
                    2'b10:   ctrl_c.branch_control = BC_LT;
                    2'b11:   ctrl_c.branch_control = BC_LTU;
                    default: illegal_c = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.src_b_imm = 1'b1;
                fmt_c            = IMM_I;
            end
            OPC_STORE: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.src_b_imm = 1'b1;
                fmt_c            = IMM_S;
            end
            OPC_LUI: begin
                ctrl_c.alu_control = ALU_LUI;
                ctrl_c.reg_write   = 1'b1;
                ctrl_c.src_b_imm   = 1'b1;
                fmt_c              = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.src_a_pc  = 1'b1;
                ctrl_c.src_b_imm = 1'b1;
                fmt_c            = IMM_U;
            end
            OPC_JAL: begin
                // ALU forms the link value from PC; the target uses ImmE.
                ctrl_c.jump      = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.src_a_pc  = 1'b1;
                fmt_c            = IMM_J;
            end
            OPC_JALR: begin
                ctrl_c.jump      = 1'b1;
                ctrl_c.jalr      = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.src_a_pc  = 1'b1;
                fmt_c            = IMM_I;
            end
            OPC_OP_FP: begin
                ctrl_c.reg_write = 1'b1;
                case (funct7)
                    F7_FSGNJ: begin
                        ctrl_c.op_swap = 1'b1;
                        ctrl_c.fp_dest = 1'b1;
                        if (funct3 == 3'b000)      ctrl_c.alu_control = ALU_FSGNJ;
                        else if (funct3 == 3'b001) ctrl_c.alu_control = ALU_FSGNJN;
                        else                       illegal_c = 1'b1;
                    end
                    F7_FMV_XW, F7_FMV_WX: begin
                        ctrl_c.alu_control = ALU_FMV;
                        ctrl_c.fp_dest     = funct7[3];
                        illegal_c          = (funct3 != 3'b000) || (rs2 != 5'd0);
                    end
                    default: illegal_c = 1'b1;
                endcase
            end
            default: illegal_c = 1'b1;
        endcase

        if (illegal_c) begin
            ctrl_c         = '0;
            ctrl_c.illegal = 1'b1;
            fmt_c          = IMM_NONE;
        end

        // x0 is never written for integer destinations
        if (!ctrl_c.fp_dest && rd == 5'd0) begin
            ctrl_c.reg_write = 1'b0;
        end
    end

    assign ctrl_o = ctrl_c;
    assign imm_o  = gen_imm(fmt_c, instr_i);

endmodule

// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
// Decodes InstrD and registers the control word into the ID/EX register.
//   clk, reset : clock, synchronous active-high reset
//   bus        : alu_decode_stage_if.slave (D-side inputs, StallE/FlushE,
//                all E-side outputs and IllegalCount)
// Register priority: reset > FlushE (bubble) > StallE (hold) > load.
// Handshake: an entry is meaningful only while ValidE=1; StallE holds the
// entry, FlushE replaces it with an all-zero bubble.
// ---------------------------------------------------------------------------
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    alu_decode_stage_if.slave  bus
);

    ctrl_t             dec_ctrl;
    logic [31:0]       dec_imm;

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [31:0]       imm_q, imm_d;
    logic [31:0]       pc_q, pc_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_en;

    alu_ctrl_dec u_dec (
        .instr_i (bus.InstrD),
        .ctrl_o  (dec_ctrl),
        .imm_o   (dec_imm)
    );

    assign load_en = !bus.FlushE && !bus.StallE;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;

        if (bus.FlushE) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            imm_d   = '0;
            pc_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
        end else if (!bus.StallE) begin
            // Data fields load regardless of InstrValidD; controls do not.
            valid_d = bus.InstrValidD;
            ctrl_d  = bus.InstrValidD ? dec_ctrl : '0;
            imm_d   = dec_imm;
            pc_d    = bus.PCD;
            rs1_d   = bus.InstrD[19:15];
            rs2_d   = bus.InstrD[24:20];
            rd_d    = bus.InstrD[11:7];
        end

        if (load_en && bus.InstrValidD && dec_ctrl.illegal && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ValidE         = valid_q;
    assign bus.ALUControlE    = ctrl_q.alu_control;
    assign bus.BranchControlE = ctrl_q.branch_control;
    assign bus.BranchInvE     = ctrl_q.branch_inv;
    assign bus.BranchE        = ctrl_q.branch;
    assign bus.JumpE          = ctrl_q.jump;
    assign bus.JalrE          = ctrl_q.jalr;
    assign bus.ALUSrcAPCE     = ctrl_q.src_a_pc;
    assign bus.ALUSrcBImmE    = ctrl_q.src_b_imm;
    assign bus.OpSwapE        = ctrl_q.op_swap;
    assign bus.RegWriteE      = ctrl_q.reg_write;
    assign bus.FpDestE        = ctrl_q.fp_dest;
    assign bus.MemReadE       = ctrl_q.mem_read;
    assign bus.MemWriteE      = ctrl_q.mem_write;
    assign bus.IllegalE       = ctrl_q.illegal;
    assign bus.ImmE           = imm_q;
    assign bus.PCE            = pc_q;
    assign bus.Rs1E           = rs1_q;
    assign bus.Rs2E           = rs2_q;
    assign bus.RdE            = rd_q;
    assign bus.IllegalCount   = cnt_q;

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Decode stage that produces the control word consumed by the integer/FP-sign ALU. Sits between IF/ID and the execute stage.
- Combinationally decodes an RV32I instruction plus the supported FP-move/sign-inject subset into ALU op, branch-compare code, operand selects and immediate.
- Registers the result into the ID/EX pipeline register, with stall (hold) and flush (bubble) control.
- Keeps a saturating count of illegal instructions.

Parameters:
CNT_W, 8, width of illegal-instruction counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
InstrValidD  in  1  Instr/PCD hold a real instruction
InstrD  in  32  fetched instruction
PCD  in  32  instruction address
StallE  in  1  hold ID/EX register contents
FlushE  in  1  load bubble into ID/EX
ValidE  out  1  execute-stage entry is valid
ALUControlE  out  7  ALU op code
BranchControlE  out  2  ALU compare: 00 none, 01 eq, 10 signed lt, 11 unsigned lt
BranchInvE  out  1  invert compare result (bne/bge/bgeu)
BranchE  out  1  conditional branch
JumpE  out  1  jal/jalr
JalrE  out  1  target is register-relative
ALUSrcAPCE  out  1  SrcA = PC (auipc, jal, jalr link)
ALUSrcBImmE  out  1  SrcB = immediate
OpSwapE  out  1  route rs2 to SrcA, rs1 to SrcB (fsgnj/fsgnjn)
ImmE  out  32  sign-extended immediate
PCE  out  32  registered PC
Rs1E, Rs2E, RdE  out  5 each  register indices
RegWriteE  out  1  write rd
FpDestE  out  1  rd is FP file
MemReadE, MemWriteE  out  1 each  load/store
IllegalE  out  1  entry is an illegal instruction
IllegalCount  out  CNT_W  saturating illegal count

Behaviour:
- ALU codes: ADD 0000000, SUB 0000001, SCOMP 0100100, SLL 0101000, SRL 0101100, SRA 0110000, AND 0110100, OR 0111000, XOR 0111100, LUI 0100000, FMV 0100001, FSGNJ 0100010, FSGNJN 0100011.
- Decode map:
  - OP/OP-IMM map funct3 to ops. SUB only for OP with funct7=0100000. SRA for funct3=101 with funct7=0100000.
  - slt/slti: SCOMP + 10. sltu/sltiu: SCOMP + 11.
  - Shift-immediate with funct7 other than 0000000/0100000 is illegal.
  - Branches use ADD for the target.
    - beq/bne: 01, Inv 0/1.
    - blt/bge: 10, Inv 0/1.
    - bltu/bgeu: 11, Inv 0/1.
    - funct3 010/011 is illegal.
  - Load/store/auipc/jal/jalr use ADD. lui uses LUI with ALUSrcBImm=1.
  - OP-FP:
    - fsgnj.s (0010000/000) → FSGNJ, OpSwap=1, FpDest=1.
    - fsgnjn.s (001) → FSGNJN, OpSwap=1, FpDest=1.
    - fmv.x.w (1110000/000) and fmv.w.x (1111000/000) → FMV, FpDest 0/1.
    - All other OP-FP encodings are illegal.
- Immediate formats: I/S/B/U/J, sign-extended from bit 31. Shift immediates are zero-extended shamt[4:0].
- Illegal or unknown opcode:
  - IllegalE=1.
  - RegWrite, MemRead, MemWrite, Branch and Jump are all 0.
  - ALUControl=ADD, BranchControl=00.
- Register update priority, evaluated each rising clk:
  - reset: all outputs 0.
  - else FlushE: bubble, meaning all control outputs 0 and ValidE=0. Data fields are don't-care but are driven 0. FlushE wins over StallE.
  - else StallE: hold all outputs.
  - else load the decoded word. ValidE=InstrValidD. If InstrValidD=0, all control outputs are 0.
- Latency: one cycle from InstrD to the E outputs.
- IllegalCount:
  - Increments by 1 on each cycle where a valid illegal instruction is loaded, i.e. no flush, no stall, InstrValidD=1.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset. It does not change when an illegal entry is flushed after it has been loaded.
- x0 destination: RegWriteE=0 whenever RdE=0 for an integer destination.

Decomposition:
- Package alu_pkg: ALU op localparams, branch-compare codes, opcode/funct constants, immediate-format enum, packed struct ctrl_t for the E-stage control word.
- Sub-module alu_ctrl_dec: purely combinational InstrD → ctrl_t + imm.
- The top level holds the ID/EX register, the stall/flush logic and the counter.

Test Plan:
- add x3,x1,x2 (0x002081B3), then sub (0x402081B3) → next cycle:
  - add: ALUControlE=0000000, RdE=3, RegWriteE=1.
  - sub: ALUControlE=0000001.
- srai x5,x6,3 (0x40335293) → ALUControlE=0110000, ImmE=3, ALUSrcBImmE=1. Same word with funct7=0100001 → IllegalE=1, IllegalCount=1.
- bne x1,x2,+8 (0x00209463) → BranchControlE=01, BranchInvE=1, BranchE=1, ImmE=8, RegWriteE=0.
- lui x7,0x12345 (0x123453B7) → ALUControlE=0100000, ImmE=0x12345000. fsgnjn.s f1,f2,f3 (0x203110D3) → 0100011, OpSwapE=1, FpDestE=1.
- Stall/flush sequence:
  - Load add, then hold StallE 2 cycles while InstrD changes → outputs unchanged.
  - Assert StallE and FlushE together → ValidE=0, all controls 0.
  - Assert reset mid-stream → all outputs 0 next edge.
- Present 0xFFFFFFFF valid for 300 cycles with CNT_W=8 → IllegalCount saturates at 255.
  - A flushed cycle does not count.
  - InstrValidD=0 does not count.
